// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file with alias tracking.
package regfile_pkg;
  localparam int DEF_WIDTH     = 32;
  localparam int DEF_A_WIDTH   = 5;
  localparam int DEF_ROB_WIDTH = 3;

  typedef logic [DEF_A_WIDTH-1:0] reg_addr_t;

  typedef struct packed {
    logic                     busy;
    logic [DEF_ROB_WIDTH-1:0] tag;
  } reg_status_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/register_file_rat_reg_status_table.sv
// Busy/tag array: rename claims, commit releases, flush clears all claims.
// Optional REGFILE_BYPASS_EN exposes a same-cycle release on the busy read ports.
module reg_status_table
  import regfile_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int ROB_WIDTH = DEF_ROB_WIDTH,
  parameter int NREAD     = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NREAD-1:0][A_WIDTH-1:0]     i_rd_addr,
  input  logic                              i_rename_en,
  input  logic [A_WIDTH-1:0]                i_rename_addr,
  input  logic [ROB_WIDTH-1:0]              i_rename_tag,
  input  logic                              i_commit_wr,
  input  logic [A_WIDTH-1:0]                i_commit_addr,
  input  logic [ROB_WIDTH-1:0]              i_commit_tag,
  input  logic                              i_flush,
  output logic [NREAD-1:0]                  o_rd_busy,
  output logic [NREAD-1:0][ROB_WIDTH-1:0]   o_rd_tag
);
  localparam int DEPTH = 2**A_WIDTH;
  localparam logic [A_WIDTH-1:0] ZERO_ADDR = A_WIDTH'(ZERO_REG);

  logic [DEPTH-1:0]     r_busy;
  logic [ROB_WIDTH-1:0] r_tag [DEPTH];
  logic                 w_release;
  logic                 w_rename;

  // A release only applies when the committing tag still owns the register.
  assign w_release = i_commit_wr & r_busy[i_commit_addr] &
                     (r_tag[i_commit_addr] == i_commit_tag);
  assign w_rename  = i_rename_en & (i_rename_addr != ZERO_ADDR) & ~i_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
      for (int i = 0; i < DEPTH; i++) r_tag[i] <= '0;
    end else if (i_flush) begin
      r_busy <= '0;
    end else begin
      if (w_release) r_busy[i_commit_addr] <= 1'b0;
      // Placed after the release so a same-register rename takes priority.
      if (w_rename) begin
        r_busy[i_rename_addr] <= 1'b1;
        r_tag[i_rename_addr]  <= i_rename_tag;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NREAD; p++) begin
      o_rd_busy[p] = r_busy[i_rd_addr[p]];
      o_rd_tag[p]  = r_tag[i_rd_addr[p]];
      if (i_rd_addr[p] == ZERO_ADDR) o_rd_busy[p] = 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (w_release && (i_rd_addr[p] == i_commit_addr)) o_rd_busy[p] = 1'b0;
`endif
    end
  end
endmodule

// File: rtl/register_file_rat.sv
// Architectural register file with alias tracking; data array plus read mux.
// Define REGFILE_BYPASS_EN to forward commit data to same-cycle reads.
module register_file_rat
  import regfile_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int ROB_WIDTH = DEF_ROB_WIDTH,
  parameter int NREAD     = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NREAD-1:0][A_WIDTH-1:0]   address,
  output logic [NREAD-1:0][WIDTH-1:0]     regValue,
  output logic [NREAD-1:0]                regBusy,
  output logic [NREAD-1:0][ROB_WIDTH-1:0] regTag,
  input  logic                            renameEn,
  input  logic [A_WIDTH-1:0]              renameAddr,
  input  logic [ROB_WIDTH-1:0]            renameTag,
  input  logic                            validCommit,
  input  logic                            regWrite,
  input  logic [A_WIDTH-1:0]              wraddress,
  input  logic [WIDTH-1:0]                wdata,
  input  logic [ROB_WIDTH-1:0]            commitTag,
  input  logic                            flush
);
  localparam int DEPTH = 2**A_WIDTH;
  localparam logic [A_WIDTH-1:0] ZERO_ADDR = A_WIDTH'(ZERO_REG);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic             w_commit_wr;

  // Gated by reset so forwarding cannot leak data while outputs must read zero.
  assign w_commit_wr = validCommit & regWrite & (wraddress != ZERO_ADDR) & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else if (w_commit_wr) begin
      r_data[wraddress] <= wdata;
    end
  end

  always_comb begin
    for (int p = 0; p < NREAD; p++) begin
      regValue[p] = r_data[address[p]];
      if (address[p] == ZERO_ADDR) regValue[p] = '0;
`ifdef REGFILE_BYPASS_EN
      if (w_commit_wr && (address[p] == wraddress)) regValue[p] = wdata;
`endif
    end
  end

  reg_status_table #(
    .A_WIDTH   (A_WIDTH),
    .ROB_WIDTH (ROB_WIDTH),
    .NREAD     (NREAD)
  ) u_status (
    .clk           (clk),
    .reset         (reset),
    .i_rd_addr     (address),
    .i_rename_en   (renameEn),
    .i_rename_addr (renameAddr),
    .i_rename_tag  (renameTag),
    .i_commit_wr   (w_commit_wr),
    .i_commit_addr (wraddress),
    .i_commit_tag  (commitTag),
    .i_flush       (flush),
    .o_rd_busy     (regBusy),
    .o_rd_tag      (regTag)
  );
endmodule

// File: tb/tb_register_file_rat.sv
// Self-checking bench for register_file_rat: directed scenarios plus random traffic
// against an array-based reference model; follows REGFILE_BYPASS_EN like the RTL.
module tb_register_file_rat;
  logic             clk = 1'b0;
  logic             reset;
  logic [1:0][4:0]  address;
  logic [1:0][31:0] regValue;
  logic [1:0]       regBusy;
  logic [1:0][2:0]  regTag;
  logic             renameEn;
  logic [4:0]       renameAddr;
  logic [2:0]       renameTag;
  logic             validCommit;
  logic             regWrite;
  logic [4:0]       wraddress;
  logic [31:0]      wdata;
  logic [2:0]       commitTag;
  logic             flush;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_data [32];
  bit          m_busy [32];
  logic [2:0]  m_tag  [32];

  register_file_rat dut (
    .clk(clk), .reset(reset), .address(address), .regValue(regValue),
    .regBusy(regBusy), .regTag(regTag), .renameEn(renameEn),
    .renameAddr(renameAddr), .renameTag(renameTag), .validCommit(validCommit),
    .regWrite(regWrite), .wraddress(wraddress), .wdata(wdata),
    .commitTag(commitTag), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: the architectural effect of one clock edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_data[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else begin
      if (validCommit && regWrite && wraddress != 0) begin
        if (m_busy[wraddress] && m_tag[wraddress] == commitTag) m_busy[wraddress] = 1'b0;
        m_data[wraddress] = wdata;
      end
      if (renameEn && renameAddr != 0 && !flush) begin
        m_busy[renameAddr] = 1'b1;
        m_tag[renameAddr]  = renameTag;
      end
      if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end
  end

  function automatic bit commit_now(input logic [4:0] a);
    return !reset && validCommit && regWrite && wraddress != 0 && a == wraddress;
  endfunction

  function automatic logic [31:0] exp_val(input logic [4:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (commit_now(a)) return wdata;
`endif
    return m_data[a];
  endfunction

  function automatic bit exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (commit_now(a) && m_busy[a] && m_tag[a] == commitTag) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("model_value[%0d]", p), regValue[p], exp_val(address[p]));
        chk($sformatf("model_busy[%0d]", p), 32'(regBusy[p]), 32'(exp_busy(address[p])));
        if (exp_busy(address[p]))
          chk($sformatf("model_tag[%0d]", p), 32'(regTag[p]), 32'(m_tag[address[p]]));
      end
    end
  end

  task automatic idle();
    renameEn = 0; renameAddr = 0; renameTag = 0;
    validCommit = 0; regWrite = 0; wraddress = 0; wdata = 0; commitTag = 0;
    flush = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic rename(input logic [4:0] a, input logic [2:0] t);
    renameEn = 1; renameAddr = a; renameTag = t;
  endtask

  task automatic commit(input logic [4:0] a, input logic [31:0] d, input logic [2:0] t);
    validCommit = 1; regWrite = 1; wraddress = a; wdata = d; commitTag = t;
  endtask

  initial begin
    reset = 1'b1;
    address = '0;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    address[0] = 2; address[1] = 3; #1;
    chk("rst_val2", regValue[0], 0);
    chk("rst_val3", regValue[1], 0);
    chk("rst_busy2", 32'(regBusy[0]), 0);
    chk("rst_busy3", 32'(regBusy[1]), 0);

    step(); rename(5, 3);
    step(); commit(5, 5, 3); address[0] = 5; #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_val5", regValue[0], 5);
    chk("byp_busy5", 32'(regBusy[0]), 0);
`else
    chk("nobyp_val5", regValue[0], 0);
    chk("nobyp_busy5", 32'(regBusy[0]), 1);
    chk("nobyp_tag5", 32'(regTag[0]), 3);
`endif
    step(); #1;
    chk("after_val5", regValue[0], 5);
    chk("after_busy5", 32'(regBusy[0]), 0);

    step(); rename(7, 1);
    step(); rename(7, 4);
    step(); commit(7, 30, 1);
    step(); address[0] = 7; #1;
    chk("stale_val7", regValue[0], 30);
    chk("stale_busy7", 32'(regBusy[0]), 1);
    chk("stale_tag7", 32'(regTag[0]), 4);
    commit(7, 31, 4);
    step(); #1;
    chk("own_busy7", 32'(regBusy[0]), 0);
    chk("own_val7", regValue[0], 31);

    rename(6, 0);
    step(); rename(6, 2); commit(6, 66, 0);
    step(); address[0] = 6; #1;
    chk("race_busy6", 32'(regBusy[0]), 1);
    chk("race_tag6", 32'(regTag[0]), 2);
    chk("race_val6", regValue[0], 66);

    rename(1, 5);
    step(); rename(2, 6);
    step(); rename(3, 7);
    step(); flush = 1; rename(4, 1); commit(1, 9, 5);
    step(); address[0] = 1; address[1] = 2; #1;
    chk("flush_busy1", 32'(regBusy[0]), 0);
    chk("flush_busy2", 32'(regBusy[1]), 0);
    chk("flush_val1", regValue[0], 9);
    address[0] = 3; address[1] = 4; #1;
    chk("flush_busy3", 32'(regBusy[0]), 0);
    chk("flush_busy4", 32'(regBusy[1]), 0);

    commit(0, 32'hFFFF_FFFF, 0); rename(0, 3); address[0] = 0; #1;
    chk("r0_val_same", regValue[0], 0);
    step(); #1;
    chk("r0_val", regValue[0], 0);
    chk("r0_busy", 32'(regBusy[0]), 0);

    rename(9, 2);
    step(); address[0] = 1; address[1] = 9; #1;
    reset = 1'b1; #1;
    chk("midrst_val1", regValue[0], 0);
    chk("midrst_busy9", 32'(regBusy[1]), 0);
    address[0] = 7; address[1] = 6; #1;
    chk("midrst_val7", regValue[0], 0);
    chk("midrst_busy6", 32'(regBusy[1]), 0);
    reset = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      validCommit = 1'($urandom);
      regWrite    = ($urandom_range(0, 3) != 0);
      wraddress   = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wdata       = $urandom;
      commitTag   = 3'($urandom);
      renameEn    = 1'($urandom);
      renameAddr  = 5'($urandom_range(0, 7));
      renameTag   = 3'($urandom);
      flush       = ($urandom_range(0, 19) == 0);
      for (int p = 0; p < 2; p++)
        address[p] = ($urandom_range(0, 2) == 0) ? wraddress : 5'($urandom_range(0, 7));
      if (c % 500 == 250) begin
        reset = 1'b1; #1;
        for (int p = 0; p < 2; p++) begin
          chk("rnd_rst_val", regValue[p], 0);
          chk("rnd_rst_busy", 32'(regBusy[p]), 0);
        end
        #1 reset = 1'b0;
      end
    end

    step();
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
